// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and helpers for the data-memory responder.
//   dmem_req_t   : captured request fields (we, addr, wdata, be)
//   dmem_rsp_t   : response fields (rdata, err)
//   dmem_state_t : responder FSM states
//   DMEM_WAIT_MAX: largest supported wait-state count
package rv32_pkg;

  localparam int unsigned DMEM_WAIT_MAX = 15;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // An access is illegal when it is not word aligned or its word index
  // falls outside the backing array.
  function automatic logic dmem_addr_err(input logic [31:0] addr,
                                         input int unsigned depth_words);
    dmem_addr_err = (addr[1:0] != 2'b00) ||
                    ({2'b00, addr[31:2]} >= 32'(depth_words));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word RAM with byte-write enables.
//   clk_i   : clock (rising edge)
//   en_i    : access enable; nothing happens to the array or read port without it
//   we_i    : 1 = write the enabled bytes, 0 = read the word onto rdata_o
//   be_i    : byte enables for writes (bit i -> bits [8i+7:8i])
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : read data, registered; holds its value until the next read
// The array has no reset: contents survive a reset of the surrounding logic.
module dmem_array #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-masked write or full-word read, one access per enabled edge.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory target with programmable wait states.
//   clk, rst                       : clock and synchronous active-high reset
//   req_valid/req_ready            : request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata/req_be : request fields, captured at handshake
//   rsp_valid/rsp_ready            : response handshake
//   rsp_rdata/rsp_err              : load data and access-error flag
// One transaction is outstanding at a time. The array is touched only on the
// edge that enters RESP, so a reset during WAIT leaves memory untouched.
module dmem_responder
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  dmem_req_t   req_q, req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_load_q, rsp_load_d;

  dmem_req_t   live_req_s;
  dmem_req_t   cur_req_s;
  logic        cur_err_s;
  logic        enter_resp_s;
  logic        ram_en_s;
  logic [31:0] ram_rdata_s;
  dmem_rsp_t   rsp_s;

  assign live_req_s = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero wait states the access happens on the handshake edge itself,
  // so the array must see the live request rather than the captured copy.
  assign cur_req_s    = (state_q == IDLE) ? live_req_s : req_q;
  assign cur_err_s    = dmem_addr_err(cur_req_s.addr, DEPTH_WORDS);
  assign enter_resp_s = (state_d == RESP) && (state_q != RESP) && !rst;
  assign ram_en_s     = enter_resp_s && !cur_err_s;

  // State, counter, captured request and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = live_req_s;
          if (WAIT_CYCLES > 0) begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // Response flags: decided when entering RESP, held while in RESP, cleared
  // otherwise. rsp_load_q selects the RAM read port onto rsp_rdata.
  always_comb begin
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = 1'b0;
    rsp_load_d  = 1'b0;
    if (enter_resp_s) begin
      rsp_err_d  = cur_err_s;
      rsp_load_d = !cur_req_s.we && !cur_err_s;
    end else if (state_d == RESP) begin
      rsp_err_d  = rsp_err_q;
      rsp_load_d = rsp_load_q;
    end else begin
      rsp_err_d  = 1'b0;
      rsp_load_d = 1'b0;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk),
    .en_i    (ram_en_s),
    .we_i    (cur_req_s.we),
    .be_i    (cur_req_s.be),
    .addr_i  (cur_req_s.addr[AW+1:2]),
    .wdata_i (cur_req_s.wdata),
    .rdata_o (ram_rdata_s)
  );

  // The RAM read register holds during RESP because no further access is
  // enabled until the next transaction enters RESP.
  assign rsp_s.rdata = rsp_load_q ? ram_rdata_s : 32'd0;
  assign rsp_s.err   = rsp_err_q;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_s.rdata;
  assign rsp_err   = rsp_s.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with WAIT_CYCLES=2 and one with WAIT_CYCLES=0,
// sharing request fields; sel steers the handshakes to one of them.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        rsp_ready = 1'b0;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic        req_ready_s, rsp_valid_s, rsp_err_s;
  logic [31:0] rsp_rdata_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  assign req_ready_s = sel ? b_req_ready : a_req_ready;
  assign rsp_valid_s = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_err_s   = sel ? b_rsp_err   : a_rsp_err;
  assign rsp_rdata_s = sel ? b_rsp_rdata : a_rsp_rdata;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected responder: handshake, latency,
  // response contents, optional backpressure, and return to IDLE.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int lat;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1({tag, "_ready"}, req_ready_s, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid_s && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk32({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk32({tag, "_rdata"}, rsp_rdata_s, exp_rd);
    chk1({tag, "_err"}, rsp_err_s, exp_err);
    for (int i = 0; i < hold; i++) begin
      chk1({tag, "_hold_valid"}, rsp_valid_s, 1'b1);
      chk32({tag, "_hold_rdata"}, rsp_rdata_s, exp_rd);
      chk1({tag, "_hold_ready"}, req_ready_s, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk1({tag, "_done_valid"}, rsp_valid_s, 1'b0);
    chk1({tag, "_done_ready"}, req_ready_s, 1'b1);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst_valid", a_rsp_valid, 1'b0);
    chk1("rst_err", a_rsp_err, 1'b0);
    chk32("rst_rdata", a_rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_ready", a_req_ready, 1'b1);

    // Full store then load
    txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 3, 32'd0, 1'b0);
    txn("ld10", 1'b0, 32'h10, 32'd0, 4'b0000, 0, 3, 32'hDEADBEEF, 1'b0);

    // Byte-enable merge, then a no-op store with be=0000
    txn("stbe", 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 3, 32'd0, 1'b0);
    txn("ldbe", 1'b0, 32'h10, 32'd0, 4'b1111, 0, 3, 32'hDE22BE44, 1'b0);
    txn("stnop", 1'b1, 32'h10, 32'h00000000, 4'b0000, 0, 3, 32'd0, 1'b0);
    txn("ldnop", 1'b0, 32'h10, 32'd0, 4'b0000, 0, 3, 32'hDE22BE44, 1'b0);

    // Error cases must not disturb word 0
    txn("st0", 1'b1, 32'h0, 32'hA5A50001, 4'b1111, 0, 3, 32'd0, 1'b0);
    txn("ldmis", 1'b0, 32'h13, 32'd0, 4'b0000, 0, 3, 32'd0, 1'b1);
    txn("stoor", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 0, 3, 32'd0, 1'b1);
    txn("stmis", 1'b1, 32'h2, 32'hFFFFFFFF, 4'b1111, 0, 3, 32'd0, 1'b1);
    txn("ld0", 1'b0, 32'h0, 32'd0, 4'b0000, 0, 3, 32'hA5A50001, 1'b0);

    // Backpressure for 5 cycles
    txn("bp", 1'b0, 32'h10, 32'd0, 4'b0000, 5, 3, 32'hDE22BE44, 1'b0);

    // Reset during WAIT abandons the store
    txn("st20", 1'b1, 32'h20, 32'h55AA55AA, 4'b1111, 0, 3, 32'd0, 1'b0);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'b1111;
    req_valid = 1'b1;
    chk1("rw_ready", a_req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk1("rw_inwait", a_req_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("rw_ready_after", a_req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1("rw_no_rsp", a_rsp_valid, 1'b0);
      @(negedge clk);
    end
    txn("ld20", 1'b0, 32'h20, 32'd0, 4'b0000, 0, 3, 32'h55AA55AA, 1'b0);

    // Zero wait states: single-cycle latency and back-to-back loads
    sel = 1'b1;
    txn("z_st40", 1'b1, 32'h40, 32'h0BADF00D, 4'b1111, 0, 1, 32'd0, 1'b0);
    txn("z_st44", 1'b1, 32'h44, 32'h12345678, 4'b1111, 0, 1, 32'd0, 1'b0);
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h40; req_be = 4'b0000;
    req_valid = 1'b1; rsp_ready = 1'b1;
    chk1("b2b_ready0", b_req_ready, 1'b1);
    @(negedge clk);
    chk1("b2b_valid0", b_rsp_valid, 1'b1);
    chk32("b2b_rdata0", b_rsp_rdata, 32'h0BADF00D);
    chk1("b2b_busy0", b_req_ready, 1'b0);
    req_addr = 32'h44;
    @(negedge clk);
    chk1("b2b_ready1", b_req_ready, 1'b1);
    chk1("b2b_idle1", b_rsp_valid, 1'b0);
    @(negedge clk);
    chk1("b2b_valid1", b_rsp_valid, 1'b1);
    chk32("b2b_rdata1", b_rsp_rdata, 32'h12345678);
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk1("b2b_end_valid", b_rsp_valid, 1'b0);
    chk1("b2b_end_ready", b_req_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the backing array (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted between request acceptance and response (legal range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 SHALL have port req_be, input, 4 bits: store byte enables, where bit i selects byte i (bits [8i+7:8i]).
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: load data.
REQ-014 SHALL have port rsp_err, output, 1 bit: the access was misaligned or out of range.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE, so at most one transaction is outstanding; req_valid outside IDLE is ignored.
REQ-017 SHALL capture req_we, req_addr, req_wdata and req_be on the handshake edge (req_valid && req_ready).
- Next state is WAIT when WAIT_CYCLES>0, with the wait counter loaded to WAIT_CYCLES-1.
- Next state is RESP when WAIT_CYCLES=0.
REQ-018 SHALL decrement the wait counter in WAIT and move to RESP on the edge where the counter equals 0.
- Resulting latency: handshake at edge T gives rsp_valid=1 from cycle T+1+WAIT_CYCLES.
REQ-019 SHALL perform the array access (store commit or load read) on the edge that enters RESP; the array is not touched before that edge.
REQ-020 SHALL, for a store, write only the bytes whose req_be bit is 1; req_be=0000 is a legal no-op store.
REQ-021 SHALL, for a store response, drive rsp_rdata=0 and rsp_err=0.
REQ-022 SHALL, for a load, return the full word at word index req_addr[31:2] on rsp_rdata; req_be is ignored for loads.
REQ-023 SHALL flag an error when req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS: rsp_err=1, rsp_rdata=0, and no write occurs.
REQ-024 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP while rsp_ready=0; there is no timeout.
REQ-025 SHALL, on rsp_valid && rsp_ready, return to IDLE on the next edge with rsp_valid=0.
- The next request can be accepted one cycle later.
- Minimum turnaround is 2+WAIT_CYCLES cycles per transaction.
REQ-026 SHALL permit req_valid to drop before a handshake with no side effects.
REQ-027 SHALL ensure that a store followed by a load to the same address returns the stored bytes (read-after-write coherent).

Reset
REQ-028 SHALL, while rst=1 at an edge, set state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready is 1 on the first cycle after reset deasserts.
REQ-029 SHALL, on reset during WAIT, abandon the pending transaction with no array write; during RESP, drop the response (the write is already committed).
REQ-030 SHALL NOT reset the array contents.

Structure
REQ-031 SHALL place in rv32_pkg:
- the typedefs dmem_req_t {we, addr, wdata, be} and dmem_rsp_t {rdata, err};
- the state enum dmem_state_t;
- the constant DMEM_WAIT_MAX=15.
REQ-032 SHALL instantiate exactly one sub-module, dmem_array: a single-port synchronous RAM with byte-write enables and no reset.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=2, store addr=0x10, wdata=0xDEADBEEF, be=1111 -> rsp_valid 3 cycles after the handshake, rsp_err=0; then a load of 0x10 -> rsp_rdata=0xDEADBEEF.
REQ-034 SHALL cover: byte-enable merge, store 0x10 wdata=0x11223344 be=0101 over 0xDEADBEEF -> a load returns 0xDE22BE44.
REQ-035 SHALL cover: errors, a load at 0x13 or a store at 0x1000 (DEPTH_WORDS=1024) -> rsp_err=1, rsp_rdata=0, and a reload of word 0 is unchanged.
REQ-036 SHALL cover: backpressure, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; acceptance -> IDLE the next cycle.
REQ-037 SHALL cover: rst pulsed during WAIT of a store to 0x20 wdata=0xCAFEF00D -> no response, and a later load of 0x20 returns the prior contents.
REQ-038 SHALL cover: WAIT_CYCLES=0 with back-to-back loads -> rsp_valid one cycle after each handshake, and a new handshake every 2 cycles.
